// File: rtl/b_type.sv
// b_type: RV32I integer execute slice with R-type ALU and registered result.
// Define B_TYPE_BRANCH_EN to build the B-type comparator and target adder.
module b_type #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] idata,
  input  logic [XLEN-1:0] iaddr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rv1,
  input  logic [XLEN-1:0] rv2,
  output logic [XLEN-1:0] regdata_R,
`ifdef B_TYPE_BRANCH_EN
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
`endif
  output logic [XLEN-1:0] regdata_Rq
);

  logic [4:0]             w_f;
  logic [4:0]             w_sh;
  logic                   w_slt;
  logic                   w_sltu;
  logic signed [XLEN-1:0] w_sra;

  assign w_f    = {idata[30], idata[25], idata[14:12]};
  assign w_sh   = rv2[4:0];
  assign w_slt  = $signed(rv1) < $signed(rv2);
  assign w_sltu = rv1 < rv2;
  assign w_sra  = $signed(rv1) >>> w_sh;

  // Unknown or unlisted keys (incl. M-ext) fall through to zero.
  always_comb begin
    regdata_R = '0;
    case (w_f)
      5'b00000: regdata_R = rv1 + rv2;
      5'b10000: regdata_R = rv1 - rv2;
      5'b00001: regdata_R = rv1 << w_sh;
      5'b00010: regdata_R = {{(XLEN-1){1'b0}}, w_slt};
      5'b00011: regdata_R = {{(XLEN-1){1'b0}}, w_sltu};
      5'b00100: regdata_R = rv1 ^ rv2;
      5'b00101: regdata_R = rv1 >> w_sh;
      5'b10101: regdata_R = w_sra;
      5'b00110: regdata_R = rv1 | rv2;
      5'b00111: regdata_R = rv1 & rv2;
      default:  regdata_R = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regdata_Rq <= '0;
    end else begin
      regdata_Rq <= regdata_R;
    end
  end

`ifdef B_TYPE_BRANCH_EN
  logic w_unused;
  assign w_unused  = ^idata;
  assign br_target = iaddr + imm;

  always_comb begin
    br_taken = 1'b0;
    case (idata[14:12])
      3'b000:  br_taken = rv1 == rv2;
      3'b001:  br_taken = rv1 != rv2;
      3'b100:  br_taken = w_slt;
      3'b101:  br_taken = !w_slt;
      3'b110:  br_taken = w_sltu;
      3'b111:  br_taken = !w_sltu;
      default: br_taken = 1'b0;
    endcase
  end
`else
  logic w_unused;
  assign w_unused = ^{idata, iaddr, imm};
`endif

endmodule

// File: tb/tb_b_type.sv
// tb_b_type: directed self-checking bench for b_type.
// Branch checks are compiled in when B_TYPE_BRANCH_EN is defined.
module tb_b_type;

  logic        clk;
  logic        reset;
  logic [31:0] idata;
  logic [31:0] iaddr;
  logic [31:0] imm;
  logic [31:0] rv1;
  logic [31:0] rv2;
  logic [31:0] regdata_R;
  logic [31:0] regdata_Rq;
`ifdef B_TYPE_BRANCH_EN
  logic        br_taken;
  logic [31:0] br_target;
`endif

  int checks = 0;
  int errors = 0;

  b_type dut (
    .clk        (clk),
    .reset      (reset),
    .idata      (idata),
    .iaddr      (iaddr),
    .imm        (imm),
    .rv1        (rv1),
    .rv2        (rv2),
    .regdata_R  (regdata_R),
`ifdef B_TYPE_BRANCH_EN
    .br_taken   (br_taken),
    .br_target  (br_target),
`endif
    .regdata_Rq (regdata_Rq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] f);
    logic [31:0] w;
    w = 32'h0000_0033;
    w[30] = f[4];
    w[25] = f[3];
    w[14:12] = f[2:0];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [4:0] f, input logic [31:0] a,
                    input logic [31:0] b);
    idata = mk(f);
    rv1 = a;
    rv2 = b;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idata = '0;
    iaddr = '0;
    imm   = '0;
    rv1   = '0;
    rv2   = '0;
    op(5'b00000, 32'd415, 32'd60);
    @(posedge clk);
    #1;
    chk("reset_rq", regdata_Rq, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    op(5'b00000, 32'd415, 32'd60);
    chk("add", regdata_R, 32'd475);
    @(posedge clk);
    #1;
    chk("add_rq", regdata_Rq, 32'd475);
    op(5'b10000, 32'd6553, 32'd653);
    chk("sub", regdata_R, 32'd5900);
    chk("rq_hold", regdata_Rq, 32'd475);
    @(posedge clk);
    #1;
    chk("sub_rq", regdata_Rq, 32'd5900);
    op(5'b00001, 32'd288, 32'd349);
    chk("sll29", regdata_R, 32'd0);
    op(5'b00001, 32'h1234_5678, 32'd32);
    chk("sll0", regdata_R, 32'h1234_5678);
    op(5'b00010, 32'd696, 32'd623);
    chk("slt_pos", regdata_R, 32'd0);
    op(5'b00010, 32'hFFFF_FFFF, 32'd1);
    chk("slt_neg", regdata_R, 32'd1);
    op(5'b00011, 32'd447, 32'd726);
    chk("sltu_lt", regdata_R, 32'd1);
    op(5'b00011, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_big", regdata_R, 32'd0);
    op(5'b00100, 32'd696, 32'd939);
    chk("xor", regdata_R, 32'd275);
    op(5'b00101, 32'd147, 32'd194);
    chk("srl", regdata_R, 32'd36);
    op(5'b00101, 32'h8000_0000, 32'd4);
    chk("srl_msb", regdata_R, 32'h0800_0000);
    op(5'b10101, 32'd848, 32'd325);
    chk("sra", regdata_R, 32'd26);
    op(5'b10101, 32'h8000_0000, 32'd4);
    chk("sra_neg", regdata_R, 32'hF800_0000);
    op(5'b10101, 32'h8765_4321, 32'hFFFF_FFE0);
    chk("sra0", regdata_R, 32'h8765_4321);
    op(5'b00110, 32'd378, 32'd960);
    chk("or", regdata_R, 32'd1018);
    op(5'b00111, 32'd404, 32'd900);
    chk("and", regdata_R, 32'd388);
    op(5'b01000, 32'd404, 32'd900);
    chk("mext", regdata_R, 32'd0);
    op(5'b11111, 32'd404, 32'd900);
    chk("undef", regdata_R, 32'd0);
    op(5'b00000, 32'h7FFF_FFFF, 32'd1);
    chk("add_wrap", regdata_R, 32'h8000_0000);
    op(5'b10000, 32'd0, 32'd1);
    chk("sub_wrap", regdata_R, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("wrap_rq", regdata_Rq, 32'hFFFF_FFFF);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", regdata_Rq, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", regdata_Rq, 32'd0);
    op(5'b00110, 32'd378, 32'd960);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_cap", regdata_Rq, 32'd1018);
`ifdef B_TYPE_BRANCH_EN
    iaddr = 32'h100;
    imm   = 32'hFFFF_FFF8;
    op(5'b00100, 32'hFFFF_FFFB, 32'd3);
    chk("blt_tk", {31'd0, br_taken}, 32'd1);
    chk("blt_tgt", br_target, 32'hF8);
    op(5'b00111, 32'hFFFF_FFFF, 32'd1);
    chk("bgeu_tk", {31'd0, br_taken}, 32'd1);
    op(5'b00101, 32'hFFFF_FFFB, 32'd3);
    chk("bge_nt", {31'd0, br_taken}, 32'd0);
    op(5'b00000, 32'd7, 32'd7);
    chk("beq_tk", {31'd0, br_taken}, 32'd1);
    op(5'b00010, 32'd7, 32'd7);
    chk("b010_nt", {31'd0, br_taken}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
